uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
// - 8-bit UART receiver (8N1, LSB first) with a receive FIFO. Sits between the board rx pin and the core's memory-mapped I/O.
// - Deserialises rx, buffers bytes for load instructions, and raises a level interrupt toward the core's interrupt input while data is pending.
// PARAMETERS
// - CLKS_PER_BIT   868   clk cycles per bit (100 MHz / 115200); must be >= 4
// - FIFO_DEPTH     8     receive FIFO entries; must be a power of 2, >= 2
// PORTS
// - clk        in   1                     system clock, rising edge
// - reset      in   1                     asynchronous, active-low reset (asserted when 0)
// - rx         in   1                     serial input, asynchronous, idles high
// - rd_en      in   1                     pop head of FIFO this cycle
// - clr_err    in   1                     clear sticky error flags
// - rd_data    out  8                     FIFO head, first-word-fall-through
// - empty      out  1                     FIFO has 0 entries
// - full       out  1                     FIFO has FIFO_DEPTH entries
// - count      out  $clog2(FIFO_DEPTH)+1  occupancy
// - frame_err  out  1                     sticky: stop bit sampled 0
// - overrun    out  1                     sticky: byte arrived while FIFO full
// - parity_err out  1                     sticky: parity mismatch (always 0 without macro)
// - rx_irq     out  1                     registered, equals !empty
// BEHAVIOUR
// - Reset (reset==0): FSM=IDLE, sync flops=1, FIFO emptied. Outputs: rd_data=0, empty=1, full=0, count=0, all error flags=0, rx_irq=0.
//   Reset mid-frame aborts the frame; no partial byte is pushed.
// - rx passes through a 2-flop synchroniser, then a 1-flop history for falling-edge detection (prev=1, cur=0).
// - FSM states and transitions:
//   - IDLE: on falling edge -> START, bit counter cleared.
//   - START: at counter == CLKS_PER_BIT/2-1, sample rx. 0 -> DATA, counter and bit index cleared. 1 -> IDLE (glitch reject, nothing flagged).
//   - DATA: sample every CLKS_PER_BIT cycles after mid-start, shift right into a shift register (LSB first).
//     After bit index 7 -> STOP, or PARITY when the macro is defined.
//   - PARITY (macro only): sample one bit, compare with even parity of the data -> STOP.
//   - STOP: sample after CLKS_PER_BIT cycles, then -> IDLE in the same cycle.
//     - Sample 1 and FIFO not full: push byte.
//     - Sample 1 and FIFO full: set overrun, drop byte.
//     - Sample 0: set frame_err, drop byte.
//     - Parity error: set parity_err, drop byte.
//     - A held-low line (break) is not re-detected until rx returns to 1, because start detection needs an edge.
// - Latency: pushed byte appears on rd_data and empty falls 1 cycle after the stop sample; rx_irq rises 1 cycle after empty falls.
// - FIFO rules:
//   - rd_en while empty is ignored and does not underflow.
//   - Push and pop in the same cycle: both succeed, count unchanged, including when full and when count==1.
//   - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is 1 bit wider.
// - Error flags: set and clr_err in the same cycle -> set wins. Errors never block later frames.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: frame is 8E1 (even parity bit between D7 and stop); PARITY state and parity_err are live.
// - UART_RX_PARITY_EN undefined: frame is 8N1; no PARITY state; parity_err tied 0.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}
//   - localparam DATA_BITS = 8
//   - localparam IDLE_LEVEL = 1'b1
// - Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, first-word-fall-through.
//   Shared with the future UART TX.
// - Top: synchroniser, bit timer, FSM and shift register; sync_fifo instance.
// TESTING (CLKS_PER_BIT=16, FIFO_DEPTH=4)
// - Reset: hold reset=0 with rx=1, release -> empty=1, count=0, rx_irq=0, flags=0.
//   Reassert reset mid-frame -> nothing pushed.
// - Single frame 0xA5 at 16 clk/bit -> rd_data=0xA5, count=1, rx_irq=1.
//   Pulse rd_en -> empty=1 next cycle, rx_irq=0 the cycle after.
// - Glitch: rx low for 4 cycles -> FSM back to IDLE, count=0, no flags.
// - Framing: frame 0x3C with stop bit 0 -> frame_err=1, count=0.
//   Next frame 0x11 is received normally.
//   clr_err -> frame_err=0.
// - Overrun/wrap: send 0x01..0x05 without reads -> full=1 after 4 bytes, overrun=1, FIFO holds 0x01..0x04.
//   Then interleave 6 pops with 2 more frames -> data in order across pointer wrap.
//   Push and pop in the same cycle -> count unchanged.
// - UART_RX_PARITY_EN: frame 0x07 with parity 1 -> accepted; with parity 0 -> parity_err=1, byte dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
// Shared by the UART receive and transmit paths.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign count_o = count_q;
  // Head is forced to zero when empty so the output is defined out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a receive FIFO, with a level interrupt
// while data is pending. Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          parity_err_o,
  output logic                          rx_irq_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HalfBit = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FullBit = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_irq_q;
  logic                 set_frame, set_overrun, set_parity;
  logic                 push;
  logic                 fifo_empty, fifo_full;
  logic                 rx_s;
  logic                 par_bad;

  assign rx_s = sync2_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign par_bad      = par_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      hist_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Receive FSM: bit timing, sampling, shift register and frame verdict.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    set_frame   = 1'b0;
    set_overrun = 1'b0;
    set_parity  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        // Needs a real 1->0 edge, so a held-low break is not re-detected.
        if (hist_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HalfBit) begin
          if (!rx_s) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;  // glitch, not a start bit
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FullBit) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != even_parity(shift_q));
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == FullBit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          set_frame  = !rx_s;
          set_parity = par_bad;
          if (rx_s && !par_bad) begin
            if (fifo_full) set_overrun = 1'b1;
            else           push        = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_comb begin
    frame_err_d  = set_frame   | (frame_err_q & ~clr_err_i);
    overrun_d    = set_overrun | (overrun_q & ~clr_err_i);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_parity  | (parity_err_q & ~clr_err_i);
`endif
  end

  // FSM, datapath and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_irq_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rx_irq_q     <= !fifo_empty;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_en_i),
    .rdata_o (rd_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  assign empty_o     = fifo_empty;
  assign full_o      = fifo_full;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign rx_irq_o    = rx_irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clk, rst_n, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun, parity_err, rx_irq;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx),
    .rd_en_i      (rd_en),
    .clr_err_i    (clr_err),
    .rd_data_o    (rd_data),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (count),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .parity_err_o (parity_err),
    .rx_irq_o     (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400us;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (rx_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", rx_irq); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err});
    end
    // Abort a frame part way through with reset.
    rx = 1'b0;
    tick(40);
    rst_n = 1'b0;
    tick(3);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(200);
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL midreset_count: got %0d want 0", count); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midreset_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rd_data); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (rx_irq !== 1'b1) begin n_bad++; $display("FAIL single_irq: got %b want 1", rx_irq); end
    pop();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL pop_empty: got %b want 1", empty); end
    n_cmp++; if (rx_irq !== 1'b1) begin n_bad++; $display("FAIL pop_irq_lag: got %b want 1", rx_irq); end
    tick(1);
    n_cmp++; if (rx_irq !== 1'b0) begin n_bad++; $display("FAIL pop_irq_fall: got %b want 0", rx_irq); end
    // Pop while empty must not underflow.
    pop();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL underflow_count: got %0d want 0", count); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", count); end
    n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_bad++; $display("FAIL glitch_flags: got %b want 000", {frame_err, overrun, parity_err});
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_set: got %b want 1", frame_err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL frame_count: got %0d want 0", count); end
    send_frame(8'h11, 1'b1);
    n_cmp++; if (rd_data !== 8'h11) begin n_bad++; $display("FAIL frame_next_data: got %h want 11", rd_data); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_sticky: got %b want 1", frame_err); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL frame_clr: got %b want 0", frame_err); end
    pop();
  endtask

  task automatic test_overrun_wrap();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 4) begin
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL fill_ovr: got %b want 0", overrun); end
      end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", count); end
    n_cmp++; if (rd_data !== 8'h01) begin n_bad++; $display("FAIL wrap_d1: got %h want 01", rd_data); end
    pop();
    n_cmp++; if (rd_data !== 8'h02) begin n_bad++; $display("FAIL wrap_d2: got %h want 02", rd_data); end
    pop();
    send_frame(8'h06, 1'b1);
    n_cmp++; if (rd_data !== 8'h03) begin n_bad++; $display("FAIL wrap_d3: got %h want 03", rd_data); end
    pop();
    n_cmp++; if (rd_data !== 8'h04) begin n_bad++; $display("FAIL wrap_d4: got %h want 04", rd_data); end
    pop();
    send_frame(8'h07, 1'b1);
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", count); end
    n_cmp++; if (rd_data !== 8'h06) begin n_bad++; $display("FAIL wrap_d6: got %h want 06", rd_data); end
    pop();
    n_cmp++; if (rd_data !== 8'h07) begin n_bad++; $display("FAIL wrap_d7: got %h want 07", rd_data); end
    pop();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  // Pop the only entry in exactly the cycle the next byte is pushed.
  task automatic test_push_pop_same_cycle();
    send_frame(8'hAA, 1'b1);
    fork
      send_frame(8'h5B, 1'b1);
      begin
        // Stop sample lands 155 edges after the start bit is driven
        // (2 sync + 1 edge detect + 8 half bit + 9 full bits).
        tick(154);
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL pp_before: got %0d want 1", count); end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL pp_count: got %0d want 1", count); end
        n_cmp++; if (rd_data !== 8'h5B) begin n_bad++; $display("FAIL pp_data: got %h want 5b", rd_data); end
      end
    join
    pop();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL pp_empty: got %b want 1", empty); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = par_bit;
    tick(CPB);
    rx = 1'b1;
    tick(CPB + 4);
  endtask

  task automatic test_parity();
    send_frame_par(8'h07, 1'b1);
    n_cmp++; if (rd_data !== 8'h07) begin n_bad++; $display("FAIL par_ok_data: got %h want 07", rd_data); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_ok_flag: got %b want 0", parity_err); end
    pop();
    send_frame_par(8'h07, 1'b0);
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL par_bad_count: got %0d want 0", count); end
  endtask
`else
  task automatic test_parity();
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_tied: got %b want 0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun_wrap();
    test_push_pop_same_cycle();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
